// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pkg
// Purpose : Shared widths, FSM state encoding and buffer entry type for the fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_ADDR_W = 7;
    localparam int FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_DATA_W-1:0] data;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_skid_buffer
// Purpose : 2-entry FIFO of {data,pc} between the instruction memory and decode.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_skid_buffer #(
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] slots [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;

    // The caller never pushes when full nor pops when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots[0] <= '0;
            slots[1] <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head      = slots[rd_ptr];
    assign empty     = (count == 2'd0);
    assign occupancy = count;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch_unit
// Purpose : PC owner and fetch FSM delivering a fixed-length program through a skid buffer.
//           Optional macro FETCH_REDIRECT_EN adds a PC redirect port with buffer flush.
// Rev     : 1.0  initial release
// ============================================================================
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int DATA_W   = FETCH_DATA_W,
    parameter int START_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cantidad_instrucciones,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              busy,
    output logic              done
`ifdef FETCH_REDIRECT_EN
    ,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`endif
);

    localparam int                CW       = ADDR_W + 2;
    localparam int                EW       = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(START_PC);

    logic [1:0]        rst_sync;
    logic              rst_n;
    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] delivered;
    logic [ADDR_W-1:0] delivered_next;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              issue;
    logic              push;
    logic              pop;
    logic              redirect_act;
    logic [ADDR_W-1:0] redirect_target;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     issued_after;
    logic [1:0]        room_used;
    logic              drain_empty;
    logic [EW-1:0]     head;
    logic              empty;
    logic [1:0]        occ;

    // Assertion is immediate; release is retimed to clk through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

`ifdef FETCH_REDIRECT_EN
    assign redirect_act    = redirect_valid && (state == FETCH || state == DRAIN);
    assign redirect_target = redirect_pc;
`else
    assign redirect_act    = 1'b0;
    assign redirect_target = '0;
`endif

    assign pop            = !empty && instr_ready;
    assign push           = inflight && !redirect_act;
    assign delivered_next = delivered + ADDR_W'(pop);
    assign outstanding    = CW'(delivered) + CW'(occ) + CW'(inflight);
    // Slot usage after this cycle's pop, so a full-rate stream keeps issuing every cycle.
    assign room_used      = occ + 2'(inflight) - 2'(pop);
    assign issue          = (state == FETCH) && !redirect_act
                            && (outstanding < CW'(count_q)) && (room_used < 2'd2);
    assign issued_after   = outstanding + CW'(issue);
    assign drain_empty    = !inflight && (occ == 2'(pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= PC_RESET;
            count_q     <= '0;
            delivered   <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            inflight  <= issue;
            delivered <= delivered_next;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + ADDR_W'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count_q   <= cantidad_instrucciones;
                        pc        <= PC_RESET;
                        delivered <= '0;
                        if (cantidad_instrucciones == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                FETCH, DRAIN: begin
                    if (redirect_act) begin
                        pc    <= redirect_target;
                        state <= (delivered_next < count_q) ? FETCH : DRAIN;
                    end else if (state == FETCH) begin
                        if (issued_after >= CW'(count_q)) begin
                            state <= DRAIN;
                        end
                    end else if (drain_empty) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_skid_buffer #(
        .WIDTH(EW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data({imem_data, inflight_pc}),
        .pop      (pop),
        .flush    (redirect_act),
        .head     (head),
        .empty    (empty),
        .occupancy(occ)
    );

    assign imem_rd_en  = issue;
    assign imem_addr   = issue ? pc : '0;
    assign instr_valid = !empty;
    assign instr_data  = empty ? '0 : head[EW-1:ADDR_W];
    assign instr_pc    = empty ? '0 : head[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instruction_fetch_unit
// Purpose : Directed vector table plus hand sequences for the fetch unit (START_PC 0 and 126).
// Rev     : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start_a;
    logic          start_b;
    logic          ready;
    logic [AW-1:0] cnt;

    logic          rd_a, rd_b, val_a, val_b, busy_a, busy_b, done_a, done_b;
    logic [AW-1:0] addr_a, addr_b, ipc_a, ipc_b;
    logic [DW-1:0] mdata_a, mdata_b, idata_a, idata_b;
`ifdef FETCH_REDIRECT_EN
    logic          redir_v;
    logic [AW-1:0] redir_pc;
`endif

    instruction_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .START_PC(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cantidad_instrucciones(cnt),
        .imem_rd_en(rd_a), .imem_addr(addr_a), .imem_data(mdata_a),
        .instr_valid(val_a), .instr_ready(ready), .instr_data(idata_a), .instr_pc(ipc_a),
        .busy(busy_a), .done(done_a)
`ifdef FETCH_REDIRECT_EN
        , .redirect_valid(redir_v), .redirect_pc(redir_pc)
`endif
    );

    instruction_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .START_PC(126)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cantidad_instrucciones(cnt),
        .imem_rd_en(rd_b), .imem_addr(addr_b), .imem_data(mdata_b),
        .instr_valid(val_b), .instr_ready(ready), .instr_data(idata_b), .instr_pc(ipc_b),
        .busy(busy_b), .done(done_b)
`ifdef FETCH_REDIRECT_EN
        , .redirect_valid(1'b0), .redirect_pc(7'd0)
`endif
    );

    // Instruction memory: mem[i] = i + 100, one cycle read latency.
    always_ff @(posedge clk) begin
        if (rd_a) mdata_a <= DW'(addr_a) + 32'd100;
        if (rd_b) mdata_b <= DW'(addr_b) + 32'd100;
    end

    logic          sel;
    logic          obs_rd, obs_val, obs_busy, obs_done;
    logic [AW-1:0] obs_addr, obs_pc;
    logic [DW-1:0] obs_data;
    always_comb begin
        obs_rd   = sel ? rd_b   : rd_a;
        obs_val  = sel ? val_b  : val_a;
        obs_busy = sel ? busy_b : busy_a;
        obs_done = sel ? done_b : done_a;
        obs_addr = sel ? addr_b : addr_a;
        obs_pc   = sel ? ipc_b  : ipc_a;
        obs_data = sel ? idata_b : idata_a;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic          st;
        logic [AW-1:0] n;
        logic          rdy;
        logic          rd;
        logic [AW-1:0] ad;
        logic          v;
        logic [DW-1:0] d;
        logic          b;
        logic          dn;
    } vec_t;

    vec_t vecs [16];

    // Start a program on the selected DUT with ready held high; checks order, pacing and done.
    task automatic run_prog(input string tag, input int n, input int first_pc);
        int got;
        int last;
        int done_at;
        int exp_pc;
        got = 0; last = -1; done_at = -1;
        @(posedge clk); #1;
        cnt = AW'(n); ready = 1'b1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int c = 1; c < 200 && done_at < 0; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            @(negedge clk);
            if (obs_val && ready) begin
                exp_pc = (first_pc + got) % 128;
                check({tag, " pc"}, 64'(obs_pc), 64'(exp_pc));
                check({tag, " data"}, 64'(obs_data), 64'(exp_pc + 100));
                check({tag, " slot"}, 64'(c), 64'(3 + got));
                got++;
                last = c;
            end
            if (obs_done) done_at = c;
        end
        check({tag, " count"}, 64'(got), 64'(n));
        check({tag, " done_cycle"}, 64'(done_at), 64'(last + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int issued;
        int taken;
        int got;
`ifdef FETCH_REDIRECT_EN
        int c_redir;
        int exp_pc;
`endif
        // test 3 (count 0) then test 2 (count 5, ready low cycles 2-6)
        vecs[0]  = '{1'b1, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0,   1'b0, 1'b0};
        vecs[1]  = '{1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0,   1'b0, 1'b1};
        vecs[2]  = '{1'b0, 7'd0, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0,   1'b0, 1'b1};
        vecs[3]  = '{1'b1, 7'd5, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0,   1'b0, 1'b1};
        vecs[4]  = '{1'b0, 7'd5, 1'b1, 1'b1, 7'd0, 1'b0, 32'd0,   1'b1, 1'b0};
        vecs[5]  = '{1'b0, 7'd5, 1'b0, 1'b1, 7'd1, 1'b0, 32'd0,   1'b1, 1'b0};
        vecs[6]  = '{1'b0, 7'd5, 1'b0, 1'b0, 7'd0, 1'b1, 32'd100, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 7'd5, 1'b0, 1'b0, 7'd0, 1'b1, 32'd100, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 7'd5, 1'b0, 1'b0, 7'd0, 1'b1, 32'd100, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 7'd5, 1'b0, 1'b0, 7'd0, 1'b1, 32'd100, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 7'd5, 1'b1, 1'b1, 7'd2, 1'b1, 32'd100, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 7'd5, 1'b1, 1'b1, 7'd3, 1'b1, 32'd101, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 7'd5, 1'b1, 1'b1, 7'd4, 1'b1, 32'd102, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 7'd5, 1'b1, 1'b0, 7'd0, 1'b1, 32'd103, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 7'd5, 1'b1, 1'b0, 7'd0, 1'b1, 32'd104, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 7'd5, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0,   1'b0, 1'b1};

        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; ready = 1'b0; cnt = '0; sel = 1'b0;
`ifdef FETCH_REDIRECT_EN
        redir_v = 1'b0; redir_pc = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rd_en_a", 64'(rd_a), 64'(0));
        check("reset addr_a", 64'(addr_a), 64'(0));
        check("reset addr_b", 64'(addr_b), 64'(0));
        check("reset valid_a", 64'(val_a), 64'(0));
        check("reset busy_a", 64'(busy_a), 64'(0));
        check("reset done_a", 64'(done_a), 64'(0));
        check("reset data_b", 64'(idata_b), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);

        issued = 0; taken = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            start_a = vecs[i].st; cnt = vecs[i].n; ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d rd_en", i), 64'(obs_rd), 64'(vecs[i].rd));
            check($sformatf("vec%0d addr", i), 64'(obs_addr), 64'(vecs[i].ad));
            check($sformatf("vec%0d valid", i), 64'(obs_val), 64'(vecs[i].v));
            check($sformatf("vec%0d busy", i), 64'(obs_busy), 64'(vecs[i].b));
            check($sformatf("vec%0d done", i), 64'(obs_done), 64'(vecs[i].dn));
            if (vecs[i].v) begin
                check($sformatf("vec%0d data", i), 64'(obs_data), 64'(vecs[i].d));
                check($sformatf("vec%0d pc", i), 64'(obs_pc), 64'(vecs[i].d - 32'd100));
            end
            issued += int'(obs_rd);
            taken  += int'(obs_val && ready);
            check($sformatf("vec%0d depth_le_2", i), 64'((issued - taken) <= 2), 64'(1));
        end
        check("vec total issued", 64'(issued), 64'(5));
        check("vec total taken", 64'(taken), 64'(5));
        @(posedge clk); #1;
        start_a = 1'b0;

        run_prog("t1", 18, 0);

        // reset in the middle of a fetch
        got = 0;
        @(posedge clk); #1;
        cnt = 7'd10; ready = 1'b1; start_a = 1'b1;
        for (int c = 1; c < 30 && got < 3; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            @(negedge clk);
            if (obs_val && ready) got++;
        end
        check("t4 transfers_before_reset", 64'(got), 64'(3));
        #1 reset = 1'b0;
        #1;
        check("t4 rd_en", 64'(rd_a), 64'(0));
        check("t4 addr", 64'(addr_a), 64'(0));
        check("t4 valid", 64'(val_a), 64'(0));
        check("t4 data", 64'(idata_a), 64'(0));
        check("t4 pc", 64'(ipc_a), 64'(0));
        check("t4 busy", 64'(busy_a), 64'(0));
        check("t4 done", 64'(done_a), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        run_prog("t4 restart", 4, 0);

        sel = 1'b1;
        run_prog("t5 wrap", 4, 126);
        sel = 1'b0;

`ifdef FETCH_REDIRECT_EN
        got = 0; c_redir = 1000;
        @(posedge clk); #1;
        cnt = 7'd6; ready = 1'b1; start_a = 1'b1;
        for (int c = 1; c < 60; c++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            redir_v  = (c == c_redir);
            redir_pc = 7'd40;
            ready    = (c != c_redir);
            @(negedge clk);
            if (c == c_redir + 1) check("t6 flushed_valid", 64'(obs_val), 64'(0));
            if (obs_val && ready) begin
                exp_pc = (got < 2) ? got : 40 + got - 2;
                check("t6 pc", 64'(obs_pc), 64'(exp_pc));
                check("t6 data", 64'(obs_data), 64'(exp_pc + 100));
                got++;
                if (got == 2) c_redir = c + 1;
            end
            if (obs_done) break;
        end
        redir_v = 1'b0;
        check("t6 delivered", 64'(got), 64'(6));
        check("t6 done", 64'(obs_done), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
